sdram_resp_model: RTL and testbench
===================================

Name: sdram_resp_model

Overview:
Synthesizable, cycle-level SDRAM device responder: the target end of the SDRAM command interface that our controller and traffic generator drive. It decodes CKE/CS/RAS/CAS/WE commands, tracks per-bank open rows, stores write data in a small aliased on-chip memory and returns read bursts after the programmed CAS latency. It lets controller regressions and FPGA loopback builds run without the vendor behavioural model, and flags protocol violations.

Parameters:
MEM_AW, 10, log2 of stored 16-bit words; the address map aliases into this depth.
COL_LSB_BITS, 5, number of column LSBs used in the storage index.

Ports:
clk  in  1  SDRAM clock; all commands sampled on the rising edge.
reset_n  in  1  asynchronous active-low reset.
cke  in  1  clock enable; when 0 the command is ignored.
ncs  in  1  chip select, active low.
nras  in  1  row strobe, active low.
ncas  in  1  column strobe, active low.
nwe  in  1  write enable, active low.
dqml  in  1  low-byte write mask.
dqmh  in  1  high-byte write mask.
a  in  13  address bus; A10 is the auto-precharge / all-banks bit.
ba  in  2  bank address.
dq_in  in  16  write data, from the bidirectional pad.
dq_out  out  16  read data.
dq_oe  out  1  read-data drive enable.
proto_err  out  1  sticky protocol-violation flag.
err_cnt  out  8  count of violations, saturating at 255.
refresh_cnt  out  16  count of AUTO REFRESH commands, wrapping.

Behaviour:
- Reset (async, reset_n=0): all banks closed, mode BL=1 and CL=2, no burst active, dq_out=0, dq_oe=0, proto_err=0, err_cnt=0, refresh_cnt=0. Memory contents are not reset. Reset mid-burst aborts the burst immediately.
- A command is valid only when cke=1 and ncs=0. {nras,ncas,nwe} decodes as:
  - 111: NOP.
  - 011: ACTIVE.
  - 101: READ.
  - 100: WRITE.
  - 010: PRECHARGE.
  - 001: AUTO REFRESH.
  - 000: LOAD MODE.
  - 110: BURST TERMINATE.
- LOAD MODE: A[2:0] sets BL (0→1, 1→2, 2→4, 3→8). A[6:4] sets CL (2 or 3). An illegal field keeps the old value and raises an error. LOAD MODE while any bank is open raises an error but is still applied.
- ACTIVE: opens bank ba with row a. ACTIVE to an already open bank raises an error; the bank is reopened with the new row.
- PRECHARGE: closes bank ba, or all banks when A10=1. Precharging a closed bank is legal.
- AUTO REFRESH: increments refresh_cnt. Raises an error if any bank is open.
- Storage index = {ba, row[MEM_AW-2-COL_LSB_BITS-1:0], col[COL_LSB_BITS-1:0]}, truncated to MEM_AW bits. Column = a[8:0].
- Bursts:
  - A burst uses sequential order and wraps within the BL-aligned block: beat k addresses col = {col[8:b], (col[b-1:0]+k) mod BL}, where b = log2(BL).
  - A WRITE or READ to a closed bank raises an error and the command is ignored.
  - If A10=1, the bank auto-closes after the last beat.
- WRITE: beat 0 data is taken from dq_in on the command cycle, beats 1..BL-1 on the following cycles. For each beat, dqml=1 masks byte [7:0] and dqmh=1 masks byte [15:8].
- READ: the command arrives at cycle T. Beat k appears on dq_out with dq_oe=1 at T+CL+k. dq_oe is 0 on all other cycles. DQM is ignored for reads.
- Interruption:
  - A new READ or WRITE truncates the current burst. A READ that follows a read burst continues the data pipeline seamlessly.
  - BURST TERMINATE stops the remaining beats of any burst; pending read beats already inside the CL pipeline are still delivered for beats with index < the cycle of termination.
  - PRECHARGE to the bursting bank also truncates the burst.
- Simultaneous events: a WRITE arriving while read data is still in flight raises an error (bus contention) and the write wins; dq_oe drops on that cycle.
- Errors: each error event sets proto_err and increments err_cnt by 1 per cycle. Both are cleared only by reset.

Test Plan:
- Reset then LOAD MODE a=0x032 (CL3, BL4), ACTIVE ba=1 row=5, WRITE col=0x04 with data 0x1111,0x2222,0x3333,0x4444, then READ col=0x06 at cycle T → dq_out shows 0x3333,0x4444,0x1111,0x2222 at T+3..T+6; dq_oe=1 only on those cycles; proto_err=0.
- BL=1, CL=2, WRITE 0xABCD with dqmh=1 over a location holding 0x1234 → a later read returns 0x12CD two cycles after the READ.
- READ to closed bank 2 → no dq_oe, proto_err=1, err_cnt=1. A second ACTIVE on an already open bank → err_cnt=2.
- BL=8 READ at T, BURST TERMINATE at T+2 with CL=2 → exactly 2 beats are driven (T+2, T+3), then dq_oe=0.
- Three AUTO REFRESH commands with all banks closed → refresh_cnt=3, proto_err=0. One with bank 0 open → refresh_cnt=4, proto_err=1.
- Assert reset_n=0 in the middle of a BL=8 read → dq_oe=0 asynchronously. After release, mode reads back as BL1/CL2 (a READ is followed by a single beat at +2).

Source files
------------

// File: rtl/sdram_resp_model.sv
// Cycle-level SDRAM target: decodes controller commands, tracks open rows, stores
// writes in an aliased on-chip array and returns read bursts after the CAS latency.
module sdram_resp_model #(
   parameter int MEM_AW       = 10,
   parameter int COL_LSB_BITS = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cke,
   input  logic        ncs,
   input  logic        nras,
   input  logic        ncas,
   input  logic        nwe,
   input  logic        dqml,
   input  logic        dqmh,
   input  logic [12:0] a,
   input  logic [1:0]  ba,
   input  logic [15:0] dq_in,
   output logic [15:0] dq_out,
   output logic        dq_oe,
   output logic        proto_err,
   output logic [7:0]  err_cnt,
   output logic [15:0] refresh_cnt
);

   localparam int ROW_BITS = MEM_AW - 2 - COL_LSB_BITS;
   localparam int DEPTH    = 1 << MEM_AW;

   typedef enum logic [2:0] {
      CMD_LMR = 3'b000,
      CMD_REF = 3'b001,
      CMD_PRE = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_BST = 3'b110,
      CMD_NOP = 3'b111
   } cmd_e;

   function automatic logic [8:0] beat_col(input logic [8:0] col, input logic [1:0] bl,
                                           input logic [2:0] k);
      logic [8:0] mask;
      mask = (9'd1 << bl) - 9'd1;
      return (col & ~mask) | ((col + {6'd0, k}) & mask);
   endfunction

   function automatic logic [2:0] len_m1(input logic [1:0] bl);
      case (bl)
         2'd0:    return 3'd0;
         2'd1:    return 3'd1;
         2'd2:    return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [MEM_AW-1:0] mem_idx(input logic [1:0] b,
                                                 input logic [ROW_BITS-1:0] row,
                                                 input logic [COL_LSB_BITS-1:0] col);
      return {b, row, col};
   endfunction

   logic [15:0]         mem_q [DEPTH];
   logic [3:0]          bank_open_q, bank_open_d;
   logic [12:0]         bank_row_q [4];
   logic [12:0]         bank_row_d [4];
   logic [1:0]          bl_q, bl_d;
   logic                cl3_q, cl3_d;
   logic                bst_act_q, bst_act_d;
   logic                bst_wr_q, bst_wr_d;
   logic [1:0]          bst_bank_q, bst_bank_d;
   logic [ROW_BITS-1:0] bst_row_q, bst_row_d;
   logic [8:0]          bst_col_q, bst_col_d;
   logic [2:0]          bst_beat_q, bst_beat_d;
   logic [1:0]          bst_bl_q, bst_bl_d;
   logic                bst_ap_q, bst_ap_d;
   logic [2:0]          pv_q, pv_d;
   logic [15:0]         pd_q [3];
   logic [15:0]         pd_d [3];
   logic [15:0]         dq_out_q, dq_out_d;
   logic                dq_oe_q, dq_oe_d;
   logic                perr_q, perr_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic [15:0]         ref_cnt_q, ref_cnt_d;

   cmd_e                cmd_s;
   logic                is_wr_s, rd_inflight_s, err_s, flush_s, cont_s;
   logic                mem_we_s, rd_push_s, out_v_s;
   logic [1:0]          mem_be_s;
   logic [MEM_AW-1:0]   mem_waddr_s, rd_addr_s, cmd_addr_s, beat_addr_s;
   logic [8:0]          beat_col_s;
   logic [15:0]         out_data_s;
   logic                unused_s;

   assign beat_col_s    = beat_col(bst_col_q, bst_bl_q, bst_beat_q);
   assign beat_addr_s   = mem_idx(bst_bank_q, bst_row_q, beat_col_s[COL_LSB_BITS-1:0]);
   assign cmd_addr_s    = mem_idx(ba, bank_row_q[ba][ROW_BITS-1:0], a[COL_LSB_BITS-1:0]);
   assign is_wr_s       = (cmd_s == CMD_WR);
   assign rd_inflight_s = (bst_act_q & ~bst_wr_q) | pv_q[0] | pv_q[1] | (cl3_q & pv_q[2]);
   assign out_v_s       = cl3_q ? pv_q[2] : pv_q[1];
   assign out_data_s    = cl3_q ? pd_q[2] : pd_q[1];
   assign unused_s      = ^{beat_col_s[8:COL_LSB_BITS], bank_row_q[0][12:ROW_BITS],
                            bank_row_q[1][12:ROW_BITS], bank_row_q[2][12:ROW_BITS],
                            bank_row_q[3][12:ROW_BITS]};

   // Command decode: anything outside a selected, clock-enabled cycle is a NOP.
   always_comb begin
      if (cke && !ncs) begin
         cmd_s = cmd_e'({nras, ncas, nwe});
      end else begin
         cmd_s = CMD_NOP;
      end
   end

   // Next-state logic for banks, mode, burst engine, read pipeline and error counters.
   always_comb begin
      bank_open_d = bank_open_q;
      bank_row_d  = bank_row_q;
      bl_d        = bl_q;
      cl3_d       = cl3_q;
      bst_act_d   = 1'b0;
      bst_wr_d    = bst_wr_q;
      bst_bank_d  = bst_bank_q;
      bst_row_d   = bst_row_q;
      bst_col_d   = bst_col_q;
      bst_beat_d  = bst_beat_q;
      bst_bl_d    = bst_bl_q;
      bst_ap_d    = bst_ap_q;
      ref_cnt_d   = ref_cnt_q;
      err_s       = 1'b0;
      flush_s     = 1'b0;
      cont_s      = bst_act_q;
      mem_we_s    = 1'b0;
      mem_be_s    = 2'b00;
      mem_waddr_s = {MEM_AW{1'b0}};
      rd_push_s   = 1'b0;
      rd_addr_s   = {MEM_AW{1'b0}};

      case (cmd_s)
         CMD_LMR: begin
            err_s = (|bank_open_q) | a[2] | ~((a[6:4] == 3'd2) | (a[6:4] == 3'd3));
            bl_d  = a[2] ? bl_q : a[1:0];
            cl3_d = (a[6:4] == 3'd3) ? 1'b1 : ((a[6:4] == 3'd2) ? 1'b0 : cl3_q);
         end
         CMD_ACT: begin
            err_s           = bank_open_q[ba];
            bank_open_d[ba] = 1'b1;
            bank_row_d[ba]  = a;
         end
         CMD_PRE: begin
            bank_open_d = a[10] ? 4'b0000 : (bank_open_q & ~(4'b0001 << ba));
            cont_s      = bst_act_q & ~(a[10] | (ba == bst_bank_q));
         end
         CMD_REF: begin
            ref_cnt_d = ref_cnt_q + 16'd1;
            err_s     = |bank_open_q;
         end
         CMD_BST: begin
            cont_s = 1'b0;
         end
         CMD_RD, CMD_WR: begin
            // A write while read data is still owed wins the bus and drops the read.
            err_s = ~bank_open_q[ba] | (is_wr_s & rd_inflight_s);
            if (bank_open_q[ba]) begin
               cont_s          = 1'b0;
               flush_s         = is_wr_s & rd_inflight_s;
               bst_act_d       = (bl_q != 2'd0);
               bst_wr_d        = is_wr_s;
               bst_bank_d      = ba;
               bst_row_d       = bank_row_q[ba][ROW_BITS-1:0];
               bst_col_d       = a[8:0];
               bst_beat_d      = 3'd1;
               bst_bl_d        = bl_q;
               bst_ap_d        = a[10];
               bank_open_d[ba] = ~(a[10] & (bl_q == 2'd0));
               mem_we_s        = is_wr_s;
               mem_be_s        = is_wr_s ? {~dqmh, ~dqml} : 2'b00;
               mem_waddr_s     = cmd_addr_s;
               rd_push_s       = ~is_wr_s;
               rd_addr_s       = cmd_addr_s;
            end else begin
               cont_s = bst_act_q;
            end
         end
         default: begin
            cont_s = bst_act_q;
         end
      endcase

      if (cont_s) begin
         mem_we_s    = bst_wr_q;
         mem_be_s    = bst_wr_q ? {~dqmh, ~dqml} : 2'b00;
         mem_waddr_s = beat_addr_s;
         rd_push_s   = ~bst_wr_q;
         rd_addr_s   = beat_addr_s;
         if (bst_beat_q == len_m1(bst_bl_q)) begin
            bank_open_d[bst_bank_q] = bank_open_d[bst_bank_q] & ~bst_ap_q;
         end else begin
            bst_act_d  = 1'b1;
            bst_beat_d = bst_beat_q + 3'd1;
         end
      end else begin
         bst_beat_d = bst_act_d ? bst_beat_d : bst_beat_q;
      end

      pv_d      = flush_s ? 3'b000 : {pv_q[1:0], rd_push_s};
      pd_d[0]   = mem_q[rd_addr_s];
      pd_d[1]   = pd_q[0];
      pd_d[2]   = pd_q[1];
      dq_oe_d   = out_v_s & ~flush_s;
      dq_out_d  = dq_oe_d ? out_data_s : 16'h0000;
      perr_d    = perr_q | err_s;
      err_cnt_d = err_cnt_q + {7'd0, err_s & (err_cnt_q != 8'hFF)};
   end

   // Byte-masked storage write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s && mem_be_s[0]) begin
         mem_q[mem_waddr_s][7:0] <= dq_in[7:0];
      end
      if (mem_we_s && mem_be_s[1]) begin
         mem_q[mem_waddr_s][15:8] <= dq_in[15:8];
      end
   end

   // State registers; reset aborts any burst and clears the output drive at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_open_q <= 4'b0000;
         bank_row_q  <= '{default: 13'h0000};
         bl_q        <= 2'd0;
         cl3_q       <= 1'b0;
         bst_act_q   <= 1'b0;
         bst_wr_q    <= 1'b0;
         bst_bank_q  <= 2'd0;
         bst_row_q   <= {ROW_BITS{1'b0}};
         bst_col_q   <= 9'd0;
         bst_beat_q  <= 3'd0;
         bst_bl_q    <= 2'd0;
         bst_ap_q    <= 1'b0;
         pv_q        <= 3'b000;
         pd_q        <= '{default: 16'h0000};
         dq_out_q    <= 16'h0000;
         dq_oe_q     <= 1'b0;
         perr_q      <= 1'b0;
         err_cnt_q   <= 8'd0;
         ref_cnt_q   <= 16'd0;
      end else begin
         bank_open_q <= bank_open_d;
         bank_row_q  <= bank_row_d;
         bl_q        <= bl_d;
         cl3_q       <= cl3_d;
         bst_act_q   <= bst_act_d;
         bst_wr_q    <= bst_wr_d;
         bst_bank_q  <= bst_bank_d;
         bst_row_q   <= bst_row_d;
         bst_col_q   <= bst_col_d;
         bst_beat_q  <= bst_beat_d;
         bst_bl_q    <= bst_bl_d;
         bst_ap_q    <= bst_ap_d;
         pv_q        <= pv_d;
         pd_q        <= pd_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         perr_q      <= perr_d;
         err_cnt_q   <= err_cnt_d;
         ref_cnt_q   <= ref_cnt_d;
      end
   end

   assign dq_out      = dq_out_q;
   assign dq_oe       = dq_oe_q;
   assign proto_err   = perr_q;
   assign err_cnt     = err_cnt_q;
   assign refresh_cnt = ref_cnt_q;

endmodule

// File: tb/tb_sdram_resp_model.sv
// Directed bench for sdram_resp_model: expected read beats go into a scoreboard queue
// tagged with their due cycle; a negedge monitor pops and compares them.
module tb_sdram_resp_model;

   localparam logic [2:0] C_LMR = 3'b000;
   localparam logic [2:0] C_REF = 3'b001;
   localparam logic [2:0] C_PRE = 3'b010;
   localparam logic [2:0] C_ACT = 3'b011;
   localparam logic [2:0] C_WR  = 3'b100;
   localparam logic [2:0] C_RD  = 3'b101;
   localparam logic [2:0] C_BST = 3'b110;
   localparam logic [2:0] C_NOP = 3'b111;

   logic        clk = 1'b0;
   logic        reset_n, cke, ncs, nras, ncas, nwe, dqml, dqmh;
   logic [12:0] a;
   logic [1:0]  ba;
   logic [15:0] dq_in, dq_out, refresh_cnt;
   logic        dq_oe, proto_err;
   logic [7:0]  err_cnt;

   typedef struct {
      int          c;
      logic [15:0] d;
   } beat_t;

   beat_t sb[$];
   int    cyc     = 0;
   int    n_pass  = 0;
   int    n_total = 0;
   int    t;

   sdram_resp_model #(.MEM_AW(10), .COL_LSB_BITS(5)) dut (
      .clk(clk), .reset_n(reset_n), .cke(cke), .ncs(ncs), .nras(nras), .ncas(ncas),
      .nwe(nwe), .dqml(dqml), .dqmh(dqmh), .a(a), .ba(ba), .dq_in(dq_in),
      .dq_out(dq_out), .dq_oe(dq_oe), .proto_err(proto_err), .err_cnt(err_cnt),
      .refresh_cnt(refresh_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Drives one command 2 ns after an edge; it is sampled by the following edge.
   task automatic drive(input logic [2:0] cmd, input logic [1:0] b, input logic [12:0] addr,
                        input logic [15:0] d, input logic mh, input logic ml);
      @(posedge clk);
      #2;
      cke = 1'b1; ncs = 1'b0; {nras, ncas, nwe} = cmd;
      ba = b; a = addr; dq_in = d; dqmh = mh; dqml = ml;
   endtask

   task automatic nop(input int n);
      repeat (n) drive(C_NOP, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic exp_beat(input int c, input logic [15:0] d);
      beat_t b;
      b.c = c;
      b.d = d;
      sb.push_back(b);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic idle();
      cke = 1'b1; ncs = 1'b1; {nras, ncas, nwe} = C_NOP;
      ba = 2'd0; a = 13'h0000; dq_in = 16'h0000; dqmh = 1'b0; dqml = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      sb.delete();
      idle();
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   // Monitor: every due beat must be driven on its cycle, and dq_oe must be low otherwise.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].c <= cyc) begin
         n_total++;
         if (sb[0].c == cyc && dq_oe === 1'b1 && dq_out === sb[0].d) n_pass++;
         else $display("FAIL read_beat@%0d: dq_oe=%b dq_out=%h, expected dq_oe=1 dq_out=%h due %0d",
                       cyc, dq_oe, dq_out, sb[0].d, sb[0].c);
         void'(sb.pop_front());
      end else if (dq_oe !== 1'b0) begin
         n_total++;
         $display("FAIL stray_oe@%0d: dq_oe=%b dq_out=%h, expected dq_oe=0", cyc, dq_oe, dq_out);
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      idle();
      #1;
      chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
      chk("rst_dq_out", {16'd0, dq_out}, 32'd0);
      chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("rst_refresh_cnt", {16'd0, refresh_cnt}, 32'd0);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;

      // CL3/BL4 wrapped write then two back-to-back wrapped reads
      drive(C_LMR, 2'd0, 13'h0032, 16'h0000, 1'b0, 1'b0);
      drive(C_ACT, 2'd1, 13'd5, 16'h0000, 1'b0, 1'b0);
      drive(C_WR, 2'd1, 13'h0004, 16'h1111, 1'b0, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 16'h2222, 1'b0, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 16'h3333, 1'b0, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 16'h4444, 1'b0, 1'b0);
      drive(C_RD, 2'd1, 13'h0006, 16'h0000, 1'b0, 1'b0);
      t = cyc + 1;
      exp_beat(t + 3, 16'h3333); exp_beat(t + 4, 16'h4444);
      exp_beat(t + 5, 16'h1111); exp_beat(t + 6, 16'h2222);
      nop(3);
      drive(C_RD, 2'd1, 13'h0005, 16'h0000, 1'b0, 1'b0);
      t = cyc + 1;
      exp_beat(t + 3, 16'h2222); exp_beat(t + 4, 16'h3333);
      exp_beat(t + 5, 16'h4444); exp_beat(t + 6, 16'h1111);
      nop(8);
      chk("t1_proto_err", {31'd0, proto_err}, 32'd0);

      // BL1/CL2 byte masks
      drive(C_PRE, 2'd0, 13'h0400, 16'h0000, 1'b0, 1'b0);
      drive(C_LMR, 2'd0, 13'h0020, 16'h0000, 1'b0, 1'b0);
      drive(C_ACT, 2'd0, 13'd2, 16'h0000, 1'b0, 1'b0);
      drive(C_WR, 2'd0, 13'h0003, 16'h1234, 1'b0, 1'b0);
      drive(C_WR, 2'd0, 13'h0003, 16'hABCD, 1'b1, 1'b0);
      drive(C_WR, 2'd0, 13'h0004, 16'h5678, 1'b0, 1'b0);
      drive(C_WR, 2'd0, 13'h0004, 16'h9ABC, 1'b0, 1'b1);
      drive(C_RD, 2'd0, 13'h0003, 16'h0000, 1'b0, 1'b0);
      t = cyc + 1;
      exp_beat(t + 2, 16'h12CD);
      drive(C_RD, 2'd0, 13'h0004, 16'h0000, 1'b0, 1'b0);
      exp_beat(t + 3, 16'h9A78);
      nop(5);
      chk("t2_proto_err", {31'd0, proto_err}, 32'd0);
      chk("t2_err_cnt", {24'd0, err_cnt}, 32'd0);

      // Protocol errors: read to closed bank, double ACTIVE
      drive(C_RD, 2'd2, 13'h0000, 16'h0000, 1'b0, 1'b0);
      nop(4);
      chk("t3_proto_err", {31'd0, proto_err}, 32'd1);
      chk("t3_err_cnt1", {24'd0, err_cnt}, 32'd1);
      drive(C_ACT, 2'd0, 13'd2, 16'h0000, 1'b0, 1'b0);
      nop(1);
      chk("t3_err_cnt2", {24'd0, err_cnt}, 32'd2);

      // BL8/CL2 read cut short by BURST TERMINATE two cycles in
      drive(C_PRE, 2'd0, 13'h0400, 16'h0000, 1'b0, 1'b0);
      drive(C_LMR, 2'd0, 13'h0023, 16'h0000, 1'b0, 1'b0);
      drive(C_ACT, 2'd3, 13'd1, 16'h0000, 1'b0, 1'b0);
      drive(C_WR, 2'd3, 13'h0000, 16'h8000, 1'b0, 1'b0);
      for (int k = 1; k < 8; k++) drive(C_NOP, 2'd0, 13'h0000, 16'h8000 + 16'(k), 1'b0, 1'b0);
      drive(C_RD, 2'd3, 13'h0000, 16'h0000, 1'b0, 1'b0);
      t = cyc + 1;
      exp_beat(t + 2, 16'h8000); exp_beat(t + 3, 16'h8001);
      drive(C_NOP, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
      drive(C_BST, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
      nop(6);
      chk("t4_err_cnt", {24'd0, err_cnt}, 32'd2);

      // AUTO REFRESH counting and refresh-with-open-bank error
      do_reset();
      drive(C_REF, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
      drive(C_REF, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
      drive(C_REF, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
      nop(1);
      chk("t5_refresh3", {16'd0, refresh_cnt}, 32'd3);
      chk("t5_proto_err0", {31'd0, proto_err}, 32'd0);
      drive(C_ACT, 2'd0, 13'd0, 16'h0000, 1'b0, 1'b0);
      drive(C_REF, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
      nop(1);
      chk("t5_refresh4", {16'd0, refresh_cnt}, 32'd4);
      chk("t5_proto_err1", {31'd0, proto_err}, 32'd1);
      chk("t5_err_cnt", {24'd0, err_cnt}, 32'd1);

      // Reset in the middle of a BL8 read, then default mode BL1/CL2
      do_reset();
      drive(C_LMR, 2'd0, 13'h0023, 16'h0000, 1'b0, 1'b0);
      drive(C_ACT, 2'd3, 13'd1, 16'h0000, 1'b0, 1'b0);
      drive(C_RD, 2'd3, 13'h0000, 16'h0000, 1'b0, 1'b0);
      t = cyc + 1;
      for (int k = 0; k < 8; k++) exp_beat(t + 2 + k, 16'h8000 + 16'(k));
      nop(4);
      chk("t6_oe_before_reset", {31'd0, dq_oe}, 32'd1);
      reset_n = 1'b0;
      sb.delete();
      idle();
      #1;
      chk("t6_async_dq_oe", {31'd0, dq_oe}, 32'd0);
      chk("t6_async_dq_out", {16'd0, dq_out}, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      drive(C_ACT, 2'd3, 13'd1, 16'h0000, 1'b0, 1'b0);
      drive(C_RD, 2'd3, 13'h0001, 16'h0000, 1'b0, 1'b0);
      t = cyc + 1;
      exp_beat(t + 2, 16'h8001);
      nop(6);
      chk("t6_proto_err", {31'd0, proto_err}, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
